// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and width helpers shared by alu_muldiv_unit and
// its iterative multiply/divide engine.
package alu_pkg;
   localparam logic [5:0] OP_NOP    = 6'd0,  OP_LUI    = 6'd1,  OP_AUIPC  = 6'd2,
                          OP_JAL    = 6'd3,  OP_ADD    = 6'd4,  OP_ADDI   = 6'd5,
                          OP_SUB    = 6'd6,  OP_AND    = 6'd7,  OP_ANDI   = 6'd8,
                          OP_OR     = 6'd9,  OP_ORI    = 6'd10, OP_XOR    = 6'd11,
                          OP_XORI   = 6'd12, OP_SLT    = 6'd13, OP_SLTI   = 6'd14,
                          OP_SLTU   = 6'd15, OP_SLTIU  = 6'd16, OP_SLL    = 6'd17,
                          OP_SLLI   = 6'd18, OP_SRL    = 6'd19, OP_SRLI   = 6'd20,
                          OP_SRA    = 6'd21, OP_SRAI   = 6'd22, OP_BEQ    = 6'd23,
                          OP_BNE    = 6'd24, OP_BLT    = 6'd25, OP_BGE    = 6'd26,
                          OP_BLTU   = 6'd27, OP_BGEU   = 6'd28, OP_MUL    = 6'd29,
                          OP_MULH   = 6'd30, OP_MULHSU = 6'd31, OP_MULHU  = 6'd32,
                          OP_DIV    = 6'd33, OP_DIVU   = 6'd34, OP_REM    = 6'd35,
                          OP_REMU   = 6'd36;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   // Slice to XLEN bits; the signed minimum is then ~(ones >> 1).
   localparam logic [127:0] ALL_ONES = '1;

   function automatic logic is_md(input logic [5:0] op);
      return op >= OP_MUL && op <= OP_REMU;
   endfunction

   function automatic logic is_div(input logic [5:0] op);
      return op >= OP_DIV && op <= OP_REMU;
   endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: bit-serial RV32M engine; shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up applied when the result is read.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             start,
   input  logic [5:0]       op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] tag,
   output logic             busy,
   output logic             done,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] res_tag
);
   localparam int CW = $clog2(XLEN);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic fin, neg, hi, sa, sb, div_op, rem_op;
   logic [2*XLEN-1:0] acc, acc_nx, prod;
   logic [XLEN-1:0] opr, ma, mb, half;
   logic [XLEN:0] sum, rem_ext, diff;

   assign div_op = is_div(op);
   assign rem_op = op == OP_REM || op == OP_REMU;
   assign sa = a[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
   assign sb = b[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
   assign ma = sa ? -a : a;
   assign mb = sb ? -b : b;

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opr} : '0);
   assign rem_ext = acc[2*XLEN-1:XLEN-1];
   assign diff = rem_ext - {1'b0, opr};
   assign acc_nx = state == MUL ? {sum, acc[XLEN-1:1]} :
                   !diff[XLEN]  ? {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = flush ? IDLE : !en ? state : state == IDLE ? (start ? (div_op ? DIV : MUL) : IDLE) : fin ? IDLE : state;

   always_comb begin
      busy = state != IDLE;
      done = busy && fin;
      prod = neg ? -acc : acc;
      half = hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      result = state == MUL ? (hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]) : (neg ? -half : half);
   end

   // fin marks the write-back cycle that follows the last iteration.
   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         fin <= 1'b0;
         neg <= 1'b0;
         hi <= 1'b0;
         acc <= '0;
         opr <= '0;
         res_tag <= '0;
      end else if (flush) begin
         cnt <= '0;
         fin <= 1'b0;
      end else if (en) begin
         if (state == IDLE && start) begin
            cnt <= CW'(XLEN - 1);
            fin <= 1'b0;
            neg <= rem_op ? sa : sa ^ sb;
            hi <= rem_op || op == OP_MULH || op == OP_MULHSU || op == OP_MULHU;
            acc <= {{XLEN{1'b0}}, div_op ? ma : mb};
            opr <= div_op ? mb : ma;
            res_tag <= tag;
         end else if (busy && !fin) begin
            acc <= acc_nx;
            cnt <= cnt - CW'(cnt != '0);
            fin <= cnt == '0;
         end else if (fin) fin <= 1'b0;
      end
endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: handshaked RV32I execution unit with a registered result.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide path.
module alu_muldiv_unit
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int OP_W  = 6
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             rdy_in,
   input  logic             flush_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);
   localparam int SH_W = $clog2(XLEN);
   logic [5:0] op;
   logic [SH_W-1:0] sh;
   logic [XLEN-1:0] alu_res, res, md_res;
   logic [TAG_W-1:0] md_tag;
   logic accept, start, load, busy, md_done;

   assign op = 6'(in_op);
   assign sh = in_b[SH_W-1:0];
   assign in_ready = rdy_in && !busy && (!out_valid || out_ready);
   assign accept = in_valid && in_ready && !flush_in;
   assign load = accept && !start;

   always_comb begin
      case (op)
         OP_LUI:                     alu_res = in_a;
         OP_AUIPC, OP_ADD, OP_ADDI:  alu_res = in_a + in_b;
         OP_JAL:                     alu_res = in_b + XLEN'(4);
         OP_SUB:                     alu_res = in_a - in_b;
         OP_AND, OP_ANDI:            alu_res = in_a & in_b;
         OP_OR, OP_ORI:              alu_res = in_a | in_b;
         OP_XOR, OP_XORI:            alu_res = in_a ^ in_b;
         OP_SLT, OP_SLTI, OP_BLT:    alu_res = XLEN'($signed(in_a) < $signed(in_b));
         OP_BGE:                     alu_res = XLEN'($signed(in_a) >= $signed(in_b));
         OP_SLTU, OP_SLTIU, OP_BLTU: alu_res = XLEN'(in_a < in_b);
         OP_BGEU:                    alu_res = XLEN'(in_a >= in_b);
         OP_BEQ:                     alu_res = XLEN'(in_a == in_b);
         OP_BNE:                     alu_res = XLEN'(in_a != in_b);
         OP_SLL, OP_SLLI:            alu_res = in_a << sh;
         OP_SRL, OP_SRLI:            alu_res = in_a >> sh;
         OP_SRA, OP_SRAI:            alu_res = $signed(in_a) >>> sh;
         default:                    alu_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam logic [XLEN-1:0] ONES = ALL_ONES[XLEN-1:0];
   localparam logic [XLEN-1:0] MIN  = ~(ONES >> 1);
   logic dz, ov, rem;

   // Divide-by-zero and signed overflow finish in one cycle without the engine.
   assign rem = op == OP_REM || op == OP_REMU;
   assign dz = is_div(op) && in_b == '0;
   assign ov = (op == OP_DIV || op == OP_REM) && in_a == MIN && in_b == ONES;
   assign start = accept && is_md(op) && !dz && !ov;
   assign res = dz ? (rem ? in_a : ONES) : ov ? (rem ? '0 : MIN) : alu_res;

   alu_muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) u_iter (
      .clk_in(clk_in), .rst_n(rst_n), .en(rdy_in), .flush(flush_in), .start(start),
      .op(op), .a(in_a), .b(in_b), .tag(in_tag),
      .busy(busy), .done(md_done), .result(md_res), .res_tag(md_tag)
   );
`else
   assign start = 1'b0;
   assign busy = 1'b0;
   assign md_done = 1'b0;
   assign md_res = '0;
   assign md_tag = '0;
   assign res = alu_res;
`endif

   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_result <= '0;
         out_tag <= '0;
      end else if (flush_in) out_valid <= 1'b0;
      else if (rdy_in) begin
         if (load) begin
            out_valid <= 1'b1;
            out_result <= res;
            out_tag <= in_tag;
         end else if (md_done) begin
            out_valid <= 1'b1;
            out_result <= md_res;
            out_tag <= md_tag;
         end else if (out_ready) out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: scoreboard bench for alu_muldiv_unit; M-extension
// expectations follow whether ALU_MULDIV_EN is defined.
module tb_alu_muldiv_unit;
   import alu_pkg::*;

`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct packed {logic [31:0] res; logic [3:0] tag;} exp_t;

   localparam int NA = 23;
   localparam logic [5:0] A_OP [NA] = '{OP_ADDI, OP_SRA, OP_BLTU, OP_BLT, OP_JAL, OP_LUI, OP_AUIPC, OP_SUB,
      OP_XORI, OP_AND, OP_OR, OP_SLL, OP_SRLI, OP_SRA, OP_SLTI, OP_SLTU, OP_BEQ, OP_BNE, OP_BGE, OP_BGEU,
      OP_NOP, 6'd63, OP_SRL};
   localparam logic [31:0] A_A [NA] = '{32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h1, 32'h0, 32'h12345000,
      32'h00001000, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1, 32'h80000000, 32'h7FFFFFF0,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h9, 32'h80000000};
   localparam logic [31:0] A_B [NA] = '{32'h1, 32'h21, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100, 32'h0,
      32'h00400000, 32'h7, 32'hFF00FF00, 32'hFF00FF00, 32'h0000000F, 32'h25, 32'h4, 32'h4,
      32'h0, 32'h0, 32'h5, 32'h5, 32'h0, 32'h0, 32'h2, 32'h9, 32'h20};
   localparam logic [31:0] A_R [NA] = '{32'h0, 32'hC0000000, 32'h1, 32'h0, 32'h104, 32'h12345000,
      32'h00401000, 32'hFFFFFFFE, 32'h0FF00FF0, 32'hF000F000, 32'hF0F0F0FF, 32'h20, 32'h08000000,
      32'h07FFFFFF, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h80000000};

   localparam int NM = 10;
   localparam logic [5:0] M_OP [NM] = '{OP_MULH, OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_MUL, OP_MULHU,
      OP_MULHSU, OP_DIVU, OP_DIV};
   localparam logic [31:0] M_A [NM] = '{32'h80000000, 32'h80000000, 32'h7, 32'hFFFFFFF9, 32'hFFFFFFF9,
      32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h5};
   localparam logic [31:0] M_B [NM] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h2, 32'h2, 32'h7,
      32'hFFFFFFFF, 32'h2, 32'd7, 32'h0};
   localparam logic [31:0] M_R [NM] = '{32'h40000000, 32'h80000000, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF,
      32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hE, 32'hFFFFFFFF};
   localparam int M_LAT [NM] = '{33, 1, 1, 33, 33, 33, 33, 33, 33, 1};

   logic clk_in = 1'b0, rst_n = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [5:0] in_op = '0;
   logic [31:0] in_a = '0, in_b = '0, out_result;
   logic [3:0] in_tag = '0, out_tag;
   exp_t q[$];
   int checks = 0, passed = 0;

   alu_muldiv_unit #(.XLEN(32), .TAG_W(4), .OP_W(6)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_tag = tag;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_in);
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'h0)
         $display("FAIL reset_outputs valid=%b result=%h tag=%h expected 0/0/0", out_valid, out_result, out_tag);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk_in);
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b expected=1", in_ready);
      else passed++;
      rdy_in = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL rdy_in_low_in_ready got=%b expected=0", in_ready);
      else passed++;
      rdy_in = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic test_alu();
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < NA; i++) begin
         drive(A_OP[i], A_A[i], A_B[i], 4'(i + 3));
         q.push_back('{res: A_R[i], tag: 4'(i + 3)});
         @(negedge clk_in);
         e = q.pop_front();
         checks++;
         if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag)
            $display("FAIL alu[%0d] op=%0d valid=%b result=%h tag=%h expected result=%h tag=%h",
                     i, A_OP[i], out_valid, out_result, out_tag, e.res, e.tag);
         else passed++;
      end
      in_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_muldiv();
      exp_t e;
      int lat;
      bit leak;
      out_ready = 1'b1;
      for (int i = 0; i < NM; i++) begin
         drive(M_OP[i], M_A[i], M_B[i], 4'(i));
         q.push_back('{res: MD ? M_R[i] : 32'h0, tag: 4'(i)});
         @(negedge clk_in);
         in_valid = 1'b0;
         lat = 1;
         leak = 1'b0;
         while (!out_valid && lat < 100) begin
            if (in_ready) leak = 1'b1;
            @(negedge clk_in);
            lat++;
         end
         e = q.pop_front();
         checks++;
         if (lat != (MD ? M_LAT[i] : 1)) $display("FAIL md_latency[%0d] got=%0d expected=%0d", i, lat, MD ? M_LAT[i] : 1);
         else passed++;
         checks++;
         if (out_result !== e.res || out_tag !== e.tag)
            $display("FAIL md_result[%0d] result=%h tag=%h expected result=%h tag=%h", i, out_result, out_tag, e.res, e.tag);
         else passed++;
         checks++;
         if (leak !== 1'b0) $display("FAIL md_in_ready_busy[%0d] got=%b expected=0", i, leak);
         else passed++;
      end
      @(negedge clk_in);
   endtask

   task automatic test_stall();
      exp_t e;
      int lat;
      out_ready = 1'b1;
      drive(OP_DIVU, 32'd100, 32'd7, 4'd2);
      q.push_back('{res: MD ? 32'hE : 32'h0, tag: 4'd2});
      @(negedge clk_in);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         rdy_in = (lat >= 2 && lat < 6) ? 1'b0 : 1'b1;
         @(negedge clk_in);
         lat++;
      end
      rdy_in = 1'b1;
      checks++;
      if (lat != (MD ? 37 : 1)) $display("FAIL stall_latency got=%0d expected=%0d", lat, MD ? 37 : 1);
      else passed++;
      e = q.pop_front();
      rdy_in = 1'b0;
      repeat (2) @(negedge clk_in);
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag || in_ready !== 1'b0)
         $display("FAIL stall_hold valid=%b result=%h tag=%h in_ready=%b expected 1/%h/%h/0",
                  out_valid, out_result, out_tag, in_ready, e.res, e.tag);
      else passed++;
      rdy_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL stall_consume valid=%b expected=0", out_valid);
      else passed++;
   endtask

   task automatic test_flush();
      int pre, post;
      out_ready = 1'b0;
      drive(OP_DIV, 32'd1000, 32'd3, 4'd9);
      @(negedge clk_in);
      in_valid = 1'b0;
      pre = 0;
      for (int k = 1; k < 10; k++) begin
         if (out_valid) pre++;
         @(negedge clk_in);
      end
      checks++;
      if (pre != (MD ? 0 : 9)) $display("FAIL flush_pre_valid got=%0d expected=%0d", pre, MD ? 0 : 9);
      else passed++;
      flush_in = 1'b1;
      drive(OP_ADD, 32'h1, 32'h1, 4'd10);
      @(negedge clk_in);
      flush_in = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_after valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      else passed++;
      post = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (out_valid) post++;
      end
      checks++;
      if (post != 0) $display("FAIL flush_no_result got=%0d expected=0", post);
      else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      out_ready = 1'b0;
      drive(OP_ADD, 32'd2, 32'd3, 4'd5);
      q.push_back('{res: 32'd5, tag: 4'd5});
      @(negedge clk_in);
      drive(OP_ADD, 32'd10, 32'd20, 4'd6);
      for (int h = 0; h < 5; h++) begin
         checks++;
         if (out_valid !== 1'b1 || out_result !== q[0].res || out_tag !== q[0].tag || in_ready !== 1'b0)
            $display("FAIL backpressure[%0d] valid=%b result=%h tag=%h in_ready=%b expected 1/%h/%h/0",
                     h, out_valid, out_result, out_tag, in_ready, q[0].res, q[0].tag);
         else passed++;
         @(negedge clk_in);
      end
      e = q.pop_front();
      out_ready = 1'b1;
      q.push_back('{res: 32'd30, tag: 4'd6});
      @(negedge clk_in);
      in_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_tag !== e.tag)
         $display("FAIL back_to_back valid=%b result=%h tag=%h expected 1/%h/%h", out_valid, out_result, out_tag, e.res, e.tag);
      else passed++;
      @(negedge clk_in);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL back_to_back_drain valid=%b expected=0", out_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int post;
      out_ready = 1'b0;
      drive(OP_MUL, 32'd3, 32'd5, 4'd7);
      @(negedge clk_in);
      in_valid = 1'b0;
      repeat (4) @(negedge clk_in);
      checks++;
      if (in_ready !== 1'b0) $display("FAIL mid_op_in_ready got=%b expected=0", in_ready);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'h0)
         $display("FAIL async_reset valid=%b result=%h tag=%h expected 0/0/0", out_valid, out_result, out_tag);
      else passed++;
      @(negedge clk_in);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b expected=1", in_ready);
      else passed++;
      post = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (out_valid) post++;
      end
      checks++;
      if (post != 0) $display("FAIL reset_kills_op got=%0d expected=0", post);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_muldiv();
      test_stall();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised, handshaked execution unit that replaces the purely combinational ALU in the reservation-station-to-CDB path. It executes all RV32I integer, branch-compare, LUI/AUIPC and JAL-link operations with a registered single-cycle result. Optionally, it also executes RV32M multiply/divide iteratively. Results carry the issuing ROB tag and are held until the broadcast stage accepts them.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- TAG_W, 4: ROB tag width.
- OP_W, 6: opcode width; 0 means no-op.
- clk_in  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state holds and no handshake completes.
- flush_in  input  1  mispredict flush; synchronous and dominant.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- in_op  input  OP_W  opcode from the shared package.
- in_a, in_b  input  XLEN  operands: rs1/rs2, or rs1/imm, or imm/pc.
- in_tag  input  TAG_W  ROB tag.
- out_valid  output  1  result register full.
- out_ready  input  1  consumer takes the result.
- out_result  output  XLEN  result; branch ops return 0/1.
- out_tag  output  TAG_W  tag of out_result.

## Operation
- Accept when in_valid && in_ready && rdy_in && !flush_in.
- in_ready = rdy_in && state==IDLE && (!out_valid || out_ready).
- Single-cycle ops: LUI→a; AUIPC/ADD/ADDI→a+b; JAL→b+4; SUB→a−b; AND/OR/XOR (reg and imm forms).
  - SLT/SLTI/BLT/BGE use signed compare; SLTU/SLTIU/BLTU/BGEU use unsigned compare; BEQ/BNE use equality. Branch ops give 1 if taken, else 0.
  - All shifts use only b[$clog2(XLEN)-1:0]; SRA/SRAI are arithmetic. This applies to register forms too.
- Unknown or zero opcode: accepted, result 0, still produces out_valid.
- FSM states:
  - IDLE: on accepting a single-cycle op, load the output register. On accepting MUL*, go to MUL. On accepting DIV*/REM*, go to DIV, except for the special cases below.
  - MUL: shift-add, 1 bit/cycle, cnt from XLEN−1 down to 0. Operands are held as magnitudes plus a sign flag. MUL keeps the low half of the product; MULH, MULHSU and MULHU keep the high half with sign fix-up. At cnt==0, load the output and return to IDLE.
  - DIV: restoring division on magnitudes, 1 bit/cycle, XLEN cycles. Signs are fixed at completion: the quotient is negated if operand signs differ; the remainder takes the dividend's sign.
- Divide special cases complete in 1 cycle from IDLE:
  - b==0 → quotient all-ones, remainder = a.
  - Signed a==MIN and b==−1 → quotient = MIN, remainder 0.
- flush_in: in the same cycle, go to IDLE, clear out_valid and cnt, and drop any offered input. in_ready is high the next cycle if rdy_in is high.
- Arithmetic wraps modulo 2^XLEN. The internal product accumulator is 2·XLEN bits.

## Timing
- Reset: out_valid=0, out_result=0, out_tag=0, state=IDLE, cnt=0. in_ready follows rdy_in from the first cycle after release.
- Single-cycle op: accepted at edge N, out_valid at N+1.
- MUL/DIV: accepted at N, out_valid at N+XLEN+1. in_ready is low from N+1 until out_valid rises and is consumed or the output is empty.
- out_valid && !out_ready: result and tag stay stable and in_ready is 0 (backpressure).
- Consume and accept in the same edge: the new single-cycle result replaces the old one and out_valid stays 1.
- rdy_in low mid-iteration: cnt and accumulators freeze, and latency stretches by the number of stalled cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

## Configuration
- ALU_MULDIV_EN defined: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU are supported as above.
- ALU_MULDIV_EN undefined: the MUL/DIV states, counter and accumulators are not built. M opcodes are treated as unknown: 1-cycle latency, result 0.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams, including the existing I-set codes plus the new M codes.
  - The FSM state enum {IDLE, MUL, DIV}.
  - Helper constants for XLEN-dependent MIN and all-ones values.
- One sub-module, alu_muldiv_iter, holds the MUL/DIV FSM and datapath. It is instantiated only under ALU_MULDIV_EN. The single-cycle datapath stays combinational in the top module.

## Test plan
- ADDI a=0xFFFFFFFF, b=1, tag=3 → out_valid one cycle later with result 0x00000000 and tag 3. SRA a=0x80000000, b=0x21 → 0xC0000000 (shift by 1).
- BLTU a=1, b=0xFFFFFFFF → 1; BLT with the same operands → 0. JAL b=0x100 → 0x104.
- MULH a=0x80000000, b=0x80000000 → 0x40000000 after 33 cycles; in_ready stays low throughout.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 in 1 cycle. REMU a=7, b=0 → 7. DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles → result stable and in_ready=0. Then assert out_ready together with a new ADD → back-to-back results with no bubble.
- Assert flush_in at cycle 10 of a DIV → out_valid never rises for it, and in_ready=1 the next cycle. Pulse rst_n low mid-MUL → outputs go to 0 asynchronously.
